halut_decoder_mc: RTL

Multi-column, integer-accumulating successor of the single-output HALUT decoder. One encoded beat (codebook index `c`, prototype index `k`) reads M LUT entries in parallel, one per output column. Each entry is accumulated into its own saturating signed accumulator, and a finished M-wide result is emitted through a valid/ready output port. The block sits after the encoder in the halutmatmul datapath. Sequence ends are marked explicitly by `last_i`, not inferred from `c_addr`.

---
 rtl/halut_decoder_mc.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/halut_decoder_mc.sv
`timescale 1ns/1ps
// halut_decoder_mc
// Multi-column HALUT decoder. Each input beat (codebook c, prototype k) reads
// one LUT entry per output column. Every column keeps its own saturating
// signed accumulator. A beat flagged last closes the sequence and moves the
// M-wide sum into a valid/ready output register.
module halut_decoder_mc #(
    parameter int unsigned K              = 16,
    parameter int unsigned C              = 32,
    parameter int unsigned M              = 4,
    parameter int unsigned DataTypeWidth  = 8,
    parameter int unsigned AccWidth       = 24,
    parameter int unsigned TotalAddrWidth = $clog2(M * C * K),
    parameter int unsigned CAddrWidth     = $clog2(C),
    parameter int unsigned TreeDepth      = $clog2(K)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    // LUT write port, address {m, c, k}
    input  logic [TotalAddrWidth-1:0]    waddr_i,
    input  logic [DataTypeWidth-1:0]     wdata_i,
    input  logic                         we_i,
    // encoded beat stream
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [CAddrWidth-1:0]        c_addr_i,
    input  logic [TreeDepth-1:0]         k_addr_i,
    input  logic                         last_i,
    // result stream
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [M*AccWidth-1:0]        result_o,
    output logic [M-1:0]                 sat_o
);

    // Per-column LUT slice is indexed by {c, k}; the column sits above it.
    localparam int unsigned LocalAddrWidth = CAddrWidth + TreeDepth;
    localparam int unsigned Depth          = C * K;

    localparam logic [AccWidth-1:0] AccMax = {1'b0, {(AccWidth-1){1'b1}}};
    localparam logic [AccWidth-1:0] AccMin = {1'b1, {(AccWidth-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage P1: the beat whose LUT entries are read this cycle
    // ------------------------------------------------------------------
    logic                  p1_valid_reg;
    logic [CAddrWidth-1:0] p1_c_reg;
    logic [TreeDepth-1:0]  p1_k_reg;
    logic                  p1_last_reg;

    logic                  out_valid_reg;
    logic                  out_valid_next;

    logic                  stall;
    logic                  accept;
    logic                  close_seq;
    logic                  absorb;

    logic [TotalAddrWidth-1:0] wcol;
    logic [LocalAddrWidth-1:0] wlocal;
    logic [LocalAddrWidth-1:0] rlocal;

    // A closing beat can only leave P1 if the output register is free or
    // being drained in this very cycle; otherwise the whole front end waits.
    assign stall      = p1_valid_reg & p1_last_reg & out_valid_reg & ~out_ready_i;
    assign in_ready_o = ~stall;
    assign accept     = in_valid_i & ~stall;

    // close_seq: P1 holds a last beat that moves into the output register.
    // absorb: P1 holds a mid-sequence beat; these never stall.
    assign close_seq  = p1_valid_reg & p1_last_reg & ~stall;
    assign absorb     = p1_valid_reg & ~p1_last_reg;

    assign wcol   = waddr_i >> LocalAddrWidth;
    assign wlocal = waddr_i[LocalAddrWidth-1:0];
    assign rlocal = {p1_c_reg, p1_k_reg};

    // Capture the accepted beat (or a bubble) whenever the pipe may advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p1_valid_reg <= 1'b0;
            p1_c_reg     <= '0;
            p1_k_reg     <= '0;
            p1_last_reg  <= 1'b0;
        end else if (!stall) begin
            p1_valid_reg <= accept;
            p1_c_reg     <= c_addr_i;
            p1_k_reg     <= k_addr_i;
            p1_last_reg  <= last_i;
        end
    end

    // A loading result wins over the clear caused by a handshake.
    always_comb begin
        out_valid_next = out_valid_reg;
        if (close_seq) begin
            out_valid_next = 1'b1;
        end else if (out_ready_i) begin
            out_valid_next = 1'b0;
        end
    end

    // Output valid flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_valid_o = out_valid_reg;

    // ------------------------------------------------------------------
    // One LUT slice, accumulator and result register per output column
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < M; gi++) begin : g_col
        logic [DataTypeWidth-1:0] lut_mem [Depth];
        logic                     col_we;
        logic [DataTypeWidth-1:0] entry_raw;
        logic [AccWidth-1:0]      entry_ext;
        logic [AccWidth:0]        sum_wide;
        logic                     ovf;
        logic [AccWidth-1:0]      sum_next;
        logic [AccWidth-1:0]      acc_reg;
        logic                     satf_reg;
        logic [AccWidth-1:0]      result_reg;
        logic                     sat_reg;

        assign col_we = we_i && (wcol == TotalAddrWidth'(gi));

        // LUT storage; a write lands at the edge, so a same-cycle read of
        // the same entry still sees the previous contents.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < Depth; i++) begin
                    lut_mem[i] <= '0;
                end
            end else if (col_we) begin
                lut_mem[wlocal] <= wdata_i;
            end
        end

        assign entry_raw = lut_mem[rlocal];
        assign entry_ext = {{(AccWidth-DataTypeWidth){entry_raw[DataTypeWidth-1]}}, entry_raw};

        // Add with one guard bit; clamp to the signed range on overflow.
        always_comb begin
            sum_wide = {acc_reg[AccWidth-1], acc_reg} + {entry_ext[AccWidth-1], entry_ext};
            ovf      = sum_wide[AccWidth] ^ sum_wide[AccWidth-1];
            sum_next = sum_wide[AccWidth-1:0];
            if (ovf) begin
                sum_next = sum_wide[AccWidth] ? AccMin : AccMax;
            end
        end

        // Running sum and sticky saturation flag; both restart after a
        // sequence closes so the next sequence begins from zero.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                acc_reg  <= '0;
                satf_reg <= 1'b0;
            end else if (close_seq) begin
                acc_reg  <= '0;
                satf_reg <= 1'b0;
            end else if (absorb) begin
                acc_reg  <= sum_next;
                satf_reg <= satf_reg | ovf;
            end
        end

        // Result register; only written when a sequence closes, so it stays
        // stable while the consumer applies backpressure.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                result_reg <= '0;
                sat_reg    <= 1'b0;
            end else if (close_seq) begin
                result_reg <= sum_next;
                sat_reg    <= satf_reg | ovf;
            end
        end

        assign result_o[gi*AccWidth +: AccWidth] = result_reg;
        assign sat_o[gi]                         = sat_reg;
    end

endmodule
